// File: rtl/ase_hssi_loopback_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : ase_hssi_loopback_mc_if
// Brief    : Bundled per-channel AXI-S TX/RX streams plus status for the
//            multi-channel HSSI loopback.
// Revision : 1.0 - initial release
// ============================================================================
interface ase_hssi_loopback_mc_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int TDATA_WIDTH  = 64,
    parameter int TUSER_WIDTH  = 1
);
    logic [NUM_CHANNELS-1:0]                   tx_tvalid;
    logic [NUM_CHANNELS-1:0]                   tx_tready;
    logic [NUM_CHANNELS-1:0]                   tx_tlast;
    logic [NUM_CHANNELS*TDATA_WIDTH-1:0]       tx_tdata;
    logic [NUM_CHANNELS*(TDATA_WIDTH/8)-1:0]   tx_tkeep;
    logic [NUM_CHANNELS*TUSER_WIDTH-1:0]       tx_tuser;
    logic [NUM_CHANNELS-1:0]                   rx_tvalid;
    logic [NUM_CHANNELS-1:0]                   rx_tlast;
    logic [NUM_CHANNELS*TDATA_WIDTH-1:0]       rx_tdata;
    logic [NUM_CHANNELS*(TDATA_WIDTH/8)-1:0]   rx_tkeep;
    logic [NUM_CHANNELS*TUSER_WIDTH-1:0]       rx_tuser;
    logic [NUM_CHANNELS-1:0]                   rx_pause;
    logic [NUM_CHANNELS*32-1:0]                tx_pkt_cnt;
    logic [NUM_CHANNELS*32-1:0]                rx_pkt_cnt;
    logic [NUM_CHANNELS-1:0]                   oversize_err;

    modport master (
        output tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, tx_tuser, rx_pause,
        input  tx_tready, rx_tvalid, rx_tlast, rx_tdata, rx_tkeep, rx_tuser,
        input  tx_pkt_cnt, rx_pkt_cnt, oversize_err
    );

    modport slave (
        input  tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, tx_tuser, rx_pause,
        output tx_tready, rx_tvalid, rx_tlast, rx_tdata, rx_tkeep, rx_tuser,
        output tx_pkt_cnt, rx_pkt_cnt, oversize_err
    );
endinterface
`default_nettype wire

// File: rtl/ase_hssi_loopback_mc.sv
`default_nettype none
// ============================================================================
// Module   : ase_hssi_loopback_mc
// Brief    : Per-channel store-and-forward loopback of TX beats onto RX with
//            inter-packet gap, pause and cut-through release of oversize pkts.
// Revision : 1.0 - initial release
// ============================================================================
module ase_hssi_loopback_mc #(
    parameter int NUM_CHANNELS = 4,
    parameter int TDATA_WIDTH  = 64,
    parameter int TUSER_WIDTH  = 1,
    parameter int DEPTH        = 64,
    parameter int IPG_CYCLES   = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ase_hssi_loopback_mc_if.slave hssi_if
);
    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int AW         = $clog2(DEPTH);
    localparam int BEAT_W     = 1 + TUSER_WIDTH + KEEP_WIDTH + TDATA_WIDTH;
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [3:0]  IPG_LAST = (IPG_CYCLES > 0) ? 4'(IPG_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Holds tready low while reset is asserted so every output reads 0.
    logic ready_en_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
        logic [BEAT_W-1:0]      mem_q [DEPTH];
        logic [AW:0]            wr_ptr_q;
        logic [AW:0]            rd_ptr_q;
        logic [AW:0]            pkt_avail_q;
        state_t                 state_q;
        logic [3:0]             gap_cnt_q;
        logic                   rx_tvalid_q;
        logic                   rx_tlast_q;
        logic [TDATA_WIDTH-1:0] rx_tdata_q;
        logic [KEEP_WIDTH-1:0]  rx_tkeep_q;
        logic [TUSER_WIDTH-1:0] rx_tuser_q;
        logic [31:0]            tx_cnt_q;
        logic [31:0]            rx_cnt_q;
        logic                   err_q;

        logic              full;
        logic              empty;
        logic              tready;
        logic              push;
        logic              push_last;
        logic              start;
        logic              pop;
        logic              pop_last;
        logic [BEAT_W-1:0] wr_beat;
        logic [BEAT_W-1:0] head;

        assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign empty     = (wr_ptr_q == rd_ptr_q);
        assign tready    = ready_en_q && !full;
        assign push      = hssi_if.tx_tvalid[ch] && tready;
        assign push_last = push && hssi_if.tx_tlast[ch];
        assign wr_beat   = {hssi_if.tx_tlast[ch],
                            hssi_if.tx_tuser[ch*TUSER_WIDTH +: TUSER_WIDTH],
                            hssi_if.tx_tkeep[ch*KEEP_WIDTH  +: KEEP_WIDTH],
                            hssi_if.tx_tdata[ch*TDATA_WIDTH +: TDATA_WIDTH]};
        assign head      = mem_q[rd_ptr_q[AW-1:0]];

        // A full FIFO with no complete packet inside can only be drained by cut-through.
        assign start     = (state_q == ST_IDLE) && !hssi_if.rx_pause[ch] &&
                           ((pkt_avail_q != '0) || full);
        assign pop       = start || ((state_q == ST_SEND) && !empty);
        assign pop_last  = pop && head[BEAT_W-1];

        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_beat;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                pkt_avail_q <= '0;
                state_q     <= ST_IDLE;
                gap_cnt_q   <= 4'd0;
                rx_tvalid_q <= 1'b0;
                rx_tlast_q  <= 1'b0;
                rx_tdata_q  <= '0;
                rx_tkeep_q  <= '0;
                rx_tuser_q  <= '0;
                tx_cnt_q    <= 32'd0;
                rx_cnt_q    <= 32'd0;
                err_q       <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;

                case ({push_last, pop_last})
                    2'b10:   pkt_avail_q <= pkt_avail_q + PTR_ONE;
                    2'b01:   pkt_avail_q <= pkt_avail_q - PTR_ONE;
                    default: pkt_avail_q <= pkt_avail_q;
                endcase

                if (push_last) tx_cnt_q <= tx_cnt_q + 32'd1;
                if (pop_last)  rx_cnt_q <= rx_cnt_q + 32'd1;

                rx_tvalid_q <= pop;
                rx_tlast_q  <= pop_last;
                if (pop) begin
                    rx_tuser_q <= head[TDATA_WIDTH+KEEP_WIDTH +: TUSER_WIDTH];
                    rx_tkeep_q <= head[TDATA_WIDTH +: KEEP_WIDTH];
                    rx_tdata_q <= head[TDATA_WIDTH-1:0];
                end

                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (pkt_avail_q == '0) err_q <= 1'b1;
                            if (!pop_last) begin
                                state_q <= ST_SEND;
                            end else if (IPG_CYCLES != 0) begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= IPG_LAST;
                            end
                        end
                    end
                    ST_SEND: begin
                        if (pop_last) begin
                            if (IPG_CYCLES != 0) begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= IPG_LAST;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_q == 4'd0) state_q   <= ST_IDLE;
                        else                   gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        assign hssi_if.tx_tready[ch]                           = tready;
        assign hssi_if.rx_tvalid[ch]                           = rx_tvalid_q;
        assign hssi_if.rx_tlast[ch]                            = rx_tlast_q;
        assign hssi_if.rx_tdata[ch*TDATA_WIDTH +: TDATA_WIDTH] = rx_tdata_q;
        assign hssi_if.rx_tkeep[ch*KEEP_WIDTH +: KEEP_WIDTH]   = rx_tkeep_q;
        assign hssi_if.rx_tuser[ch*TUSER_WIDTH +: TUSER_WIDTH] = rx_tuser_q;
        assign hssi_if.tx_pkt_cnt[ch*32 +: 32]                 = tx_cnt_q;
        assign hssi_if.rx_pkt_cnt[ch*32 +: 32]                 = rx_cnt_q;
        assign hssi_if.oversize_err[ch]                        = err_q;
    end
endmodule
`default_nettype wire
